// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: sample format, complex type and the
// half-scaling helper used when MDC_COMMUTATOR_SCALE_EN is defined.
package fft_pkg;

    localparam int DW        = 16;
    localparam int FRAC_BITS = 8;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    // (x + 1) >>> 1 evaluated at DW+1 bits, then truncated back to DW.
    // Bits [DW:1] of the widened sum are exactly that shifted result.
    function automatic logic signed [DW-1:0] scale_half(input logic signed [DW-1:0] x);
        logic signed [DW:0] w_sum;
        w_sum = {x[DW-1], x} + (DW+1)'(1);
        return w_sum[DW:1];
    endfunction

endpackage

// File: rtl/mdc_delay_line.sv
// Enable-gated fixed delay of DEPTH beats. A ring buffer is used for
// DEPTH > 1, a single register for DEPTH == 1. Contents are not reset.
module mdc_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 1) begin : g_reg
            logic [WIDTH-1:0] r_q;

            // Single-stage delay, advances only on enabled beats
            always_ff @(posedge clk) begin
                if (en) r_q <= din;
            end

            assign dout = r_q;
        end else begin : g_ring
            localparam int PW = $clog2(DEPTH);

            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [PW-1:0]    r_ptr;

            // Write at the pointer and advance; the slot being overwritten
            // holds the sample written DEPTH beats ago. Only the relative
            // pointer position matters, so the pointer needs no reset.
            always_ff @(posedge clk) begin
                if (en) begin
                    r_mem[r_ptr] <= din;
                    r_ptr        <= r_ptr + PW'(1);
                end
            end

            assign dout = r_mem[r_ptr];
        end
    endgenerate

endmodule

// File: rtl/mdc_commutator.sv
// R2MDC delay-switch-delay commutator: regroups the two butterfly output
// streams into (A, B) operand pairs of span DELAY for the next stage.
// Optional MDC_COMMUTATOR_SCALE_EN halves every output component
// (round-half-up); otherwise data passes through bit-exact.
module mdc_commutator #(
    parameter int DW    = fft_pkg::DW,
    parameter int DELAY = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] X0_re,
    input  logic [DW-1:0] X0_im,
    input  logic [DW-1:0] X1_re,
    input  logic [DW-1:0] X1_im,
    output logic          out_valid,
    output logic [DW-1:0] A_re,
    output logic [DW-1:0] A_im,
    output logic [DW-1:0] B_re,
    output logic [DW-1:0] B_im,
    output logic          out_group
);
    import fft_pkg::*;

    localparam int LG = $clog2(DELAY);      // phase bit index
    localparam int TW = LG + 1;             // counter modulo 2*DELAY
    localparam int PW = $clog2(DELAY + 1);  // prime counter saturates at DELAY

    logic [TW-1:0]   r_t;
    logic [PW-1:0]   r_prime;
    logic            w_beat;
    logic            w_p;
    logic            w_primed;
    logic [2*DW-1:0] w_top;
    logic [2*DW-1:0] w_bd;
    logic [2*DW-1:0] w_ain;
    logic [2*DW-1:0] w_a;
    logic [2*DW-1:0] w_bsel;
    logic [DW-1:0]   w_a_re;
    logic [DW-1:0]   w_a_im;
    logic [DW-1:0]   w_b_re;
    logic [DW-1:0]   w_b_im;

    logic            r_out_valid;
    logic            r_out_group;
    logic [DW-1:0]   r_a_re;
    logic [DW-1:0]   r_a_im;
    logic [DW-1:0]   r_b_re;
    logic [DW-1:0]   r_b_im;

    // Reset wins over a coincident beat, so that beat never touches state
    assign w_beat   = in_valid & ~rst;
    assign w_p      = r_t[LG];
    assign w_primed = (r_prime == PW'(DELAY));

    // Beat counter; 2*DELAY is a power of two so it wraps without a bubble
    always_ff @(posedge clk) begin
        if (rst)         r_t <= '0;
        else if (in_valid) r_t <= r_t + TW'(1);
    end

    // Counts the first DELAY beats after reset, then holds
    always_ff @(posedge clk) begin
        if (rst)                         r_prime <= '0;
        else if (in_valid && !w_primed)  r_prime <= r_prime + PW'(1);
    end

    assign w_top = {X0_re, X0_im};

    mdc_delay_line #(
        .DEPTH (DELAY),
        .WIDTH (2*DW)
    ) u_bdel (
        .clk  (clk),
        .en   (w_beat),
        .din  ({X1_re, X1_im}),
        .dout (w_bd)
    );

    // Switch: phase 0 routes top into the A line and delayed bottom to B;
    // phase 1 crosses them over
    assign w_ain  = w_p ? w_bd  : w_top;
    assign w_bsel = w_p ? w_top : w_bd;

    mdc_delay_line #(
        .DEPTH (DELAY),
        .WIDTH (2*DW)
    ) u_adel (
        .clk  (clk),
        .en   (w_beat),
        .din  (w_ain),
        .dout (w_a)
    );

`ifdef MDC_COMMUTATOR_SCALE_EN
    assign w_a_re = scale_half(w_a[2*DW-1:DW]);
    assign w_a_im = scale_half(w_a[DW-1:0]);
    assign w_b_re = scale_half(w_bsel[2*DW-1:DW]);
    assign w_b_im = scale_half(w_bsel[DW-1:0]);
`else
    assign w_a_re = w_a[2*DW-1:DW];
    assign w_a_im = w_a[DW-1:0];
    assign w_b_re = w_bsel[2*DW-1:DW];
    assign w_b_im = w_bsel[DW-1:0];
`endif

    // Output register: loads only when a primed beat completes a pair, so
    // data holds steady through gaps and stays zero until the first pair
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_group <= 1'b0;
            r_a_re      <= '0;
            r_a_im      <= '0;
            r_b_re      <= '0;
            r_b_im      <= '0;
        end else begin
            r_out_valid <= w_beat && w_primed;
            if (w_beat && w_primed) begin
                r_out_group <= ~w_p;
                r_a_re      <= w_a_re;
                r_a_im      <= w_a_im;
                r_b_re      <= w_b_re;
                r_b_im      <= w_b_im;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_group = r_out_group;
    assign A_re      = r_a_re;
    assign A_im      = r_a_im;
    assign B_re      = r_b_re;
    assign B_im      = r_b_im;

endmodule

// File: tb/tb_mdc_commutator.sv
// Scoreboard bench for mdc_commutator: a DELAY=4 and a DELAY=1 instance.
// Expected pairs are queued as beats are issued; monitors pop on out_valid.
module tb_mdc_commutator;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ar;
        logic [15:0] ai;
        logic [15:0] br;
        logic [15:0] bi;
        logic        g;
    } pair_t;

    pair_t q4[$];
    pair_t q1[$];
    pair_t m4, m1, e;

    int n_vec = 0;
    int n_err = 0;

    // DELAY = 4 instance
    logic          rst4, iv4, ov4, og4;
    logic [DW-1:0] x0r4, x0i4, x1r4, x1i4, ar4, ai4, br4, bi4;
    // DELAY = 1 instance
    logic          rst1, iv1, ov1, og1;
    logic [DW-1:0] x0r1, x0i1, x1r1, x1i1, ar1, ai1, br1, bi1;

    logic [15:0] hx4r[64], hx4i[64], hy4r[64], hy4i[64];
    logic [15:0] hx1r[64], hx1i[64], hy1r[64], hy1i[64];
    int          n4, n1;
    logic [15:0] last_ar4;

    mdc_commutator #(.DW(DW), .DELAY(4)) u4 (
        .clk(clk), .rst(rst4), .in_valid(iv4),
        .X0_re(x0r4), .X0_im(x0i4), .X1_re(x1r4), .X1_im(x1i4),
        .out_valid(ov4), .A_re(ar4), .A_im(ai4), .B_re(br4), .B_im(bi4),
        .out_group(og4)
    );

    mdc_commutator #(.DW(DW), .DELAY(1)) u1 (
        .clk(clk), .rst(rst1), .in_valid(iv1),
        .X0_re(x0r1), .X0_im(x0i1), .X1_re(x1r1), .X1_im(x1i1),
        .out_valid(ov1), .A_re(ar1), .A_im(ai1), .B_re(br1), .B_im(bi1),
        .out_group(og1)
    );

    function automatic logic [15:0] sc(input logic [15:0] v);
`ifdef MDC_COMMUTATOR_SCALE_EN
        logic [16:0] s;
        s = {v[15], v} + 17'd1;
        return s[16:1];
`else
        return v;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // One accepted beat on the DELAY=4 instance; queues the pair it completes
    task automatic beat4(input logic [15:0] xr, input logic [15:0] xi,
                         input logic [15:0] yr, input logic [15:0] yi);
        pair_t p;
        x0r4 = xr; x0i4 = xi; x1r4 = yr; x1i4 = yi; iv4 = 1'b1;
        hx4r[n4] = xr; hx4i[n4] = xi; hy4r[n4] = yr; hy4i[n4] = yi;
        if (n4 >= 4) begin
            if ((n4 % 8) >= 4)
                p = '{sc(hx4r[n4-4]), sc(hx4i[n4-4]), sc(xr), sc(xi), 1'b0};
            else
                p = '{sc(hy4r[n4-8]), sc(hy4i[n4-8]), sc(hy4r[n4-4]), sc(hy4i[n4-4]), 1'b1};
            q4.push_back(p);
            last_ar4 = p.ar;
        end
        n4++;
        @(posedge clk); #1;
        iv4 = 1'b0;
    endtask

    task automatic beat1(input logic [15:0] xr, input logic [15:0] xi,
                         input logic [15:0] yr, input logic [15:0] yi);
        pair_t p;
        x0r1 = xr; x0i1 = xi; x1r1 = yr; x1i1 = yi; iv1 = 1'b1;
        hx1r[n1] = xr; hx1i[n1] = xi; hy1r[n1] = yr; hy1i[n1] = yi;
        if (n1 >= 1) begin
            if ((n1 % 2) == 1)
                p = '{sc(hx1r[n1-1]), sc(hx1i[n1-1]), sc(xr), sc(xi), 1'b0};
            else
                p = '{sc(hy1r[n1-2]), sc(hy1i[n1-2]), sc(hy1r[n1-1]), sc(hy1i[n1-1]), 1'b1};
            q1.push_back(p);
        end
        n1++;
        @(posedge clk); #1;
        iv1 = 1'b0;
    endtask

    // Idle cycles: no output beat and held data must not move
    task automatic idle4(input int c);
        for (int i = 0; i < c; i++) begin
            @(posedge clk); #1;
            chk("gap_hold", {47'd0, ov4, ar4}, {47'd0, 1'b0, last_ar4});
        end
    endtask

    task automatic rst4_pulse(input logic with_valid);
        rst4 = 1'b1; iv4 = with_valid;
        x0r4 = 16'd55; x0i4 = 16'd55; x1r4 = 16'd55; x1i4 = 16'd55;
        @(posedge clk); #1;
        chk("rst4_outs", {ar4, ai4, br4, bi4}, 64'd0);
        chk("rst4_flags", {62'd0, ov4, og4}, 64'd0);
        rst4 = 1'b0; iv4 = 1'b0;
        n4 = 0; last_ar4 = 16'd0;
    endtask

    // Monitors: compare every presented pair against the scoreboard head
    always @(negedge clk) begin
        if (ov4) begin
            if (q4.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL u4_unexpected got A_re=%h exp no output", ar4);
            end else begin
                m4 = q4.pop_front();
                chk("u4_pair", {ar4, ai4, br4, bi4}, {m4.ar, m4.ai, m4.br, m4.bi});
                chk("u4_group", {63'd0, og4}, {63'd0, m4.g});
            end
        end
    end

    always @(negedge clk) begin
        if (ov1) begin
            if (q1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL u1_unexpected got A_re=%h exp no output", ar1);
            end else begin
                m1 = q1.pop_front();
                chk("u1_pair", {ar1, ai1, br1, bi1}, {m1.ar, m1.ai, m1.br, m1.bi});
                chk("u1_group", {63'd0, og1}, {63'd0, m1.g});
            end
        end
    end

    logic [15:0] ea, eb;

    initial begin
        rst4 = 1'b1; iv4 = 1'b0; x0r4 = '0; x0i4 = '0; x1r4 = '0; x1i4 = '0;
        rst1 = 1'b1; iv1 = 1'b0; x0r1 = '0; x0i1 = '0; x1r1 = '0; x1i1 = '0;
        n4 = 0; n1 = 0; last_ar4 = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_u4", {ov4, og4, ar4, ai4, br4, bi4}, 64'd0);
        chk("reset_u1", {ov1, og1, ar1, ai1, br1, bi1}, 64'd0);
        rst4 = 1'b0; rst1 = 1'b0;

        // Continuous stream, k = 0..15
        for (int k = 0; k < 16; k++)
            beat4(16'(k), 16'(-k), 16'(100 + k), 16'd0);
        idle4(2);

        // Same stream with 3-cycle gaps after beats 2 and 9
        rst4_pulse(1'b0);
        for (int k = 0; k < 16; k++) begin
            beat4(16'(k), 16'(-k), 16'(100 + k), 16'd0);
            if (k == 2 || k == 9) idle4(3);
        end
        idle4(1);

        // Reset mid-stream after beat 6; reset coincides with a valid beat
        rst4_pulse(1'b0);
        for (int k = 0; k < 7; k++)
            beat4(16'(k), 16'(-k), 16'(100 + k), 16'd0);
        rst4_pulse(1'b1);
        for (int k = 0; k < 8; k++) begin
            beat4(16'(k), 16'(-k), 16'(100 + k), 16'd0);
            if (k == 3) chk("prime_after_rst", {63'd0, ov4}, 64'd0);
        end
        idle4(2);

        // DELAY = 1, including scaling corner values
        beat1(16'd7, 16'd1, 16'hFFFF, 16'd2);
        beat1(16'hFFF9, 16'd3, 16'd9, 16'd4);
`ifdef MDC_COMMUTATOR_SCALE_EN
        ea = 16'd4; eb = 16'hFFFD;
`else
        ea = 16'd7; eb = 16'hFFF9;
`endif
        chk("d1_pair0_re", {32'd0, ar1, br1}, {32'd0, ea, eb});
        beat1(16'h7FFF, 16'd5, 16'd300, 16'd6);
        beat1(16'h8000, 16'd7, 16'hFED4, 16'd8);
`ifdef MDC_COMMUTATOR_SCALE_EN
        ea = 16'h4000; eb = 16'hC000;
`else
        ea = 16'h7FFF; eb = 16'h8000;
`endif
        chk("d1_pair2_re", {32'd0, ar1, br1}, {32'd0, ea, eb});
        beat1(16'd11, 16'd9, 16'd21, 16'd10);
        beat1(16'd12, 16'd11, 16'd22, 16'd12);
        repeat (3) @(posedge clk);
        #1;

        chk("u4_drained", 64'(q4.size()), 64'd0);
        chk("u1_drained", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdc_commutator.md
# mdc_commutator

Delay-switch-delay commutator for the R2MDC FFT pipeline. It takes the two parallel complex output streams of one `bf_radix2` stage (Y0 on the top path, Y1 on the bottom path). It regroups them into the (A, B) operand pairs required by the next butterfly stage, whose element span is DELAY. The block is data-driven: every accepted input beat advances the delay lines and, once primed, produces exactly one output pair.

## Interface
- DW, 16: component width; signed two's complement Q7.8 (256 = 1.0)
- DELAY, 4: delay-line depth D in beats; power of two, ≥1; equals the next stage's butterfly span
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  beat qualifier for X0/X1
- X0_re, X0_im  in  DW each  top-path sample (previous stage Y0)
- X1_re, X1_im  in  DW each  bottom-path sample (previous stage Y1)
- out_valid  out  1  output beat qualifier
- A_re, A_im, B_re, B_im  out  DW each  next-stage butterfly operands
- out_group  out  1  0 = pair drawn from top stream, 1 = pair drawn from bottom stream

## Operation
- Beat counter t counts accepted beats (in_valid=1) modulo 2D. Phase p = bit log2(D) of t, so p toggles every D beats. For D=1, p = t[0].
- Bottom pre-delay: b_d = X1 delayed by D accepted beats.
- Switch, p=0: the A-delay input takes X0, and B takes b_d.
- Switch, p=1: the A-delay input takes b_d, and B takes X0.
- A post-delay: A = the A-delay input delayed by D accepted beats.
- Both delay lines shift only on accepted beats. in_valid=0 freezes all state.
- Prime counter saturates at D. Output beats are suppressed until D beats have been accepted since reset.
- out_group = ~p of the beat that produced the pair.
- Resulting order for top stream x_k and bottom stream y_k:
  - (x_i, x_{i+D}) for i = 0..D-1
  - then (y_i, y_{i+D}) for i = 0..D-1
  - then the same pattern repeats on the next 2D-block.
- No flush is provided: the last D bottom samples emerge only when later beats are accepted.

## Timing
- Outputs are registered. out_valid=1 in the cycle after each accepted beat whose index (since reset) is ≥ D. Otherwise out_valid=0.
- Latency from the accepted beat that completes a pair to that pair on the outputs: 1 cycle.
- Throughput: one pair per cycle under continuous in_valid.
- Reset values: out_valid=0, out_group=0, A/B all components 0, t=0, prime=0.
- Delay-line contents are not reset; they are masked by the prime counter.
- Reset mid-stream discards all in-flight data. The first output after reset follows the D-th accepted beat plus 1 cycle.
- Reset has priority over in_valid in the same cycle; that beat is dropped.
- Counter wrap 2D-1 → 0 occurs without a bubble.

## Configuration
- MDC_COMMUTATOR_SCALE_EN defined: each A/B component is halved with round-half-up, computed as (x + 1) >>> 1 at DW+1 bits and then truncated to DW. This can never overflow. It is block scaling for a 1-bit per-stage growth budget.
- Macro undefined: components pass through bit-exact.
- out_valid timing is identical in both builds.

## Structure
- Package fft_pkg holds:
  - DW = 16 and FRAC_BITS = 8
  - the packed complex typedef cplx_t {re, im}
  - a scaling helper function used under the macro
- Sub-module mdc_delay_line:
  - parameters DEPTH and WIDTH; ports clk, en, din, dout
  - circular buffer with a log2(DEPTH) pointer, or a register chain when DEPTH=1
  - instantiated twice, with WIDTH = 2·DW
- Top level holds the counter, phase, prime logic, switch and output registers.

## Test plan
- D=4, continuous stream, X0 = k + j(−k) and X1 = 100+k + j0 for k = 0..15 → 12 output pairs:
  - (0,4),(1,5),(2,6),(3,7) with out_group=0
  - (100,104),(101,105),(102,106),(103,107) with out_group=1
  - (8,12),(9,13),(10,14),(11,15) with out_group=0
  - im components follow with sign negated on the x pairs.
- Same stream with in_valid held low for 3 cycles after beats 2 and 9 → identical pair sequence; out_valid is low during the gaps and the data does not change.
- rst pulsed after beat 6, then the stream restarts at k=0 → out_valid=0 and outputs are 0 during reset; the first pair (0,4) appears 1 cycle after the 4th new beat.
- D=1, X0 = x_k and X1 = y_k → pairs (x0,x1),(y0,y1),(x2,x3),(y2,y3), with out_group alternating 0,1.
- MDC_COMMUTATOR_SCALE_EN, D=1, x0 = 7, x1 = −7 → A_re = 4, B_re = −3. With x0 = 0x7FFF and x1 = 0x8000 → A_re = 0x4000, B_re = 0xC000.
- rst asserted together with in_valid on beat 0 → the beat is dropped; priming requires D further beats.
